// File: rtl/tx_bram_player.sv
// Waveform player: reads samples from a BRAM port and emits them one per sample period.
// Optional build macro TX_BRAM_LOOP_EN adds loop_i for continuous (wrapping) playback.
module tx_bram_player #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
`ifdef TX_BRAM_LOOP_EN
  input  logic              loop_i,
`endif
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [DIV_W-1:0]  rate_div_i,
  output logic              enb_o,
  output logic [ADDR_W-1:0] addrb_o,
  input  logic [DATA_W-1:0] dob_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DIV_W-1:0]    pm1_q, pm1_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                first_q, first_d;
  logic                loop_q, loop_d;

  logic                enb_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   sample_d;
  logic                valid_d;
  logic                busy_d;
  logic                done_d;

  logic                loop_in;
  logic                is_last;
  logic                more;
  logic [ADDR_W-1:0]   next_addr;
  logic                enter_emit;

`ifdef TX_BRAM_LOOP_EN
  assign loop_in = loop_i;
`else
  assign loop_in = 1'b0;
`endif

  // addrb_o always holds the address of the sample currently in the pipeline.
  assign is_last   = (addrb_o == last_q);
  assign more      = !is_last || loop_q;
  assign next_addr = is_last ? '0 : addrb_o + 1'b1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    pm1_d      = pm1_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    first_d    = first_q;
    loop_d     = loop_q;
    enb_d      = 1'b0;
    addr_d     = addrb_o;
    sample_d   = sample_o;
    valid_d    = 1'b0;
    busy_d     = busy_o;
    done_d     = 1'b0;
    enter_emit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          last_d  = last_addr_i;
          // A period below 3 cycles cannot cover the read-capture-emit pipeline.
          pm1_d   = (rate_div_i < DIV_W'(2)) ? DIV_W'(2) : rate_div_i;
          loop_d  = loop_in;
          first_d = 1'b1;
          cnt_d   = '0;
          enb_d   = 1'b1;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        hold_d = dob_i;
        if (first_q) begin
          enter_emit = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Expires on the cycle the count would reach zero.
        if (cnt_q == DIV_W'(1)) begin
          enter_emit = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EMIT: begin
        sample_d = hold_q;
        valid_d  = 1'b1;
        cnt_d    = pm1_q;
        first_d  = 1'b0;
        state_d  = enb_o ? S_CAPTURE : S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        sample_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The read for the following sample overlaps the emit of the current one.
    if (enter_emit) begin
      state_d = S_EMIT;
      enb_d   = more;
      if (more) begin
        addr_d = next_addr;
      end
    end

    if (abort_i) begin
      state_d  = S_IDLE;
      enb_d    = 1'b0;
      sample_d = '0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_d    = '0;
      first_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_q         <= '0;
      pm1_q          <= '0;
      cnt_q          <= '0;
      hold_q         <= '0;
      first_q        <= 1'b0;
      loop_q         <= 1'b0;
      enb_o          <= 1'b0;
      addrb_o        <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      pm1_q          <= pm1_d;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      first_q        <= first_d;
      loop_q         <= loop_d;
      enb_o          <= enb_d;
      addrb_o        <= addr_d;
      sample_o       <= sample_d;
      sample_valid_o <= valid_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
    end
  end

endmodule

// File: tb/tb_tx_bram_player.sv
// Directed bench for tx_bram_player with a one-cycle-latency BRAM model holding ram[i]=i+1.
module tb_tx_bram_player;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 18;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              abort_i;
`ifdef TX_BRAM_LOOP_EN
  logic              loop_i;
`endif
  logic [ADDR_W-1:0] last_addr_i;
  logic [DIV_W-1:0]  rate_div_i;
  logic              enb_o;
  logic [ADDR_W-1:0] addrb_o;
  logic [DATA_W-1:0] dob_i = '0;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              busy_o;
  logic              done_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int          strobe_cyc[$];
  int          strobe_val[$];
  int          enb_addr[$];
  int          done_cyc[$];
  logic [DATA_W-1:0] done_sample;
  logic              done_busy;

  tx_bram_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
`ifdef TX_BRAM_LOOP_EN
    .loop_i        (loop_i),
`endif
    .last_addr_i   (last_addr_i),
    .rate_div_i    (rate_div_i),
    .enb_o         (enb_o),
    .addrb_o       (addrb_o),
    .dob_i         (dob_i),
    .sample_o      (sample_o),
    .sample_valid_o(sample_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (enb_o) dob_i <= DATA_W'(addrb_o) + DATA_W'(1);
  end

  always @(negedge clk) begin
    if (sample_valid_o) begin
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(int'(sample_o));
    end
    if (enb_o) enb_addr.push_back(int'(addrb_o));
    if (done_o) begin
      done_cyc.push_back(cyc);
      done_sample = sample_o;
      done_busy   = busy_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    strobe_cyc.delete();
    strobe_val.delete();
    enb_addr.delete();
    done_cyc.delete();
    done_sample = 'x;
    done_busy   = 1'bx;
  endtask

  task automatic start_run(input int last, input int rd, output int s);
    last_addr_i = ADDR_W'(last);
    rate_div_i  = DIV_W'(rd);
    start_i     = 1'b1;
    s           = cyc;
    tick();
    start_i     = 1'b0;
    // Parameters must have been latched at start; scramble them afterwards.
    last_addr_i = ADDR_W'(5);
    rate_div_i  = DIV_W'(9);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_enb"},   enb_o, 0);
    check({tag, "_addr"},  addrb_o, 0);
    check({tag, "_smp"},   sample_o, 0);
    check({tag, "_valid"}, sample_valid_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
  endtask

  // Single-shot run checked against a schedule derived from last and rate_div; poke pulses start_i mid-run.
  task automatic play(input string tag, input int last, input int rd, input bit poke);
    int s, p, n, fin, bad_t, bad_v, bad_a;
    clear_logs();
    p   = ((rd < 2) ? 2 : rd) + 1;
    n   = last + 1;
    start_run(last, rd, s);
    fin = s + 4 + (n - 1) * p + 1;
    @(negedge clk);
    check({tag, "_busy_rise"}, busy_o, 1);
    check({tag, "_first_enb"}, enb_o, 1);
    while (cyc < fin + 3) begin
      tick();
      start_i = poke && (cyc == s + 6 || cyc == s + 13);
      if (poke && cyc == s + 7) begin
        @(negedge clk);
        check({tag, "_hold"}, sample_o, 1);
      end
    end
    start_i = 1'b0;
    bad_t = 0; bad_v = 0; bad_a = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= strobe_cyc.size() || strobe_cyc[k] != s + 4 + k * p) bad_t++;
      if (k >= strobe_val.size() || strobe_val[k] != k + 1) bad_v++;
      if (k >= enb_addr.size() || enb_addr[k] != k) bad_a++;
    end
    check({tag, "_n_strobe"}, strobe_cyc.size(), n);
    check({tag, "_strobe_time_err"}, bad_t, 0);
    check({tag, "_strobe_val_err"}, bad_v, 0);
    check({tag, "_n_reads"}, enb_addr.size(), n);
    check({tag, "_addr_seq_err"}, bad_a, 0);
    check({tag, "_n_done"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0] - s, fin - s);
    check({tag, "_done_smp"}, done_sample, 0);
    check({tag, "_done_busy"}, done_busy, 0);
    check({tag, "_end_busy"}, busy_o, 0);
  endtask

  initial begin
    int s, n_enb, n_str, bad;
    rst         = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    last_addr_i = '0;
    rate_div_i  = '0;
`ifdef TX_BRAM_LOOP_EN
    loop_i      = 1'b0;
`endif
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (5) tick();

    // Nominal: last=3, rate_div=4 -> strobes at S+4,+9,+14,+19, done at S+20.
    play("basic", 3, 4, 1'b0);
    // Same run with start_i pulses while busy must be identical.
    play("restart_ign", 3, 4, 1'b1);
    // rate_div below 2 is clamped to a 3-cycle period.
    play("clamp", 1, 0, 1'b0);
    // Single-sample playback.
    play("single", 0, 6, 1'b0);

    // Abort one cycle after the second strobe.
    clear_logs();
    start_run(7, 4, s);
    while (cyc < s + 10) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_o, 0);
    check("abort_smp", sample_o, 0);
    check("abort_enb", enb_o, 0);
    n_enb = enb_addr.size();
    repeat (30) tick();
    check("abort_reads", n_enb, 3);
    check("abort_no_more_reads", enb_addr.size(), n_enb);
    check("abort_n_strobe", strobe_cyc.size(), 2);
    check("abort_no_done", done_cyc.size(), 0);

    // Abort wins over start in the same IDLE cycle.
    clear_logs();
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    check("prio_busy", busy_o, 0);
    repeat (10) tick();
    check("prio_no_reads", enb_addr.size(), 0);

    // Reset mid-playback discards the transfer.
    clear_logs();
    start_run(7, 3, s);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    n_str = strobe_cyc.size();
    repeat (40) tick();
    check("midrst_no_strobe", strobe_cyc.size(), n_str);
    check("midrst_no_done", done_cyc.size(), 0);

    // Full memory at minimum period: 512 strobes, no wrap read.
    play("full", 511, 2, 1'b0);

`ifdef TX_BRAM_LOOP_EN
    clear_logs();
    loop_i = 1'b1;
    start_run(2, 2, s);
    loop_i = 1'b0;
    repeat (40) tick();
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (k >= enb_addr.size() || enb_addr[k] != k % 3) bad++;
      if (k >= strobe_val.size() || strobe_val[k] != k % 3 + 1) bad++;
    end
    check("loop_seq_err", bad, 0);
    check("loop_no_done", done_cyc.size(), 0);
    check("loop_busy", busy_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    check("loop_abort_busy", busy_o, 0);
    loop_i = 1'b1;
    start_run(2, 2, s);
    loop_i = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_outputs_zero("loop_rst");
    rst = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
